branch_resolution_unit: RTL
===========================

// Module: branch_resolution_unit
// PURPOSE
//  Execute-side partner of the fetch-stage branch history table. Carries each fetch prediction
//  (PC, taken bit, predicted target) through D and E, resolves it against the real outcome
//  in E, drives the BHT update port (update_en / PC_E / branch_taken_E), raises mispredict
//  flush + redirect PC, and keeps saturating branch / mispredict performance counters.
// PARAMETERS
//  CNT_W   32  width of each performance counter (saturating)
// PORTS
//  clk               in   1   clock; all state updates on posedge
//  rst               in   1   asynchronous, active-high reset
//  valid_F           in   1   a real instruction is in fetch this cycle
//  PC_F              in   32  fetch PC
//  predict_taken_F   in   1   BHT direction prediction for PC_F
//  pred_target_F     in   32  target fetch was redirected to when predict_taken_F=1
//  stall_D           in   1   hazard unit holds D register
//  stall_E           in   1   hazard unit holds E register
//  flush_D           in   1   hazard unit bubbles D
//  flush_E           in   1   hazard unit bubbles E
//  is_branch_E       in   1   instruction in E is a conditional branch
//  branch_cond_E     in   1   actual branch outcome (1 = taken)
//  branch_target_E   in   32  computed branch target
//  mispredict_E      out  1   combinational: redirect fetch and flush F/D this cycle
//  redirect_PC_E     out  32  combinational: correct next PC when mispredict_E=1, else 0
//  update_en         out  1   registered BHT update strobe
//  PC_E              out  32  registered PC of the resolved branch (BHT index source)
//  branch_taken_E    out  1   registered actual outcome for BHT training
//  branch_count      out  CNT_W  resolved conditional branches
//  mispredict_count  out  CNT_W  mispredicts (any cause)
// BEHAVIOUR
//  - Pipe regs D and E each hold {valid, pc, pred, pred_target}. Per stage, priority:
//    rst > flush (or internal mispredict for D) > stall (hold) > advance.
//  - E <- D when !stall_E; if stall_D=1 and stall_E=0, E loads a bubble (valid=0).
//  - resolve = valid_E & !stall_E; nothing below fires unless resolve=1 (exactly once/instr).
//  - Mispredict (resolve=1), redirect_PC_E:
//    pred=1, branch, not taken   -> PC+4
//    pred=0, branch, taken       -> branch_target_E
//    pred=1, branch, taken, pred_target != branch_target_E -> branch_target_E
//    pred=1, !is_branch_E (alias) -> PC+4
//    PC+4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
//  - mispredict_E also invalidates D on the same edge (own flush, in addition to flush_D).
//  - BHT update: on resolve & is_branch_E, next cycle update_en=1, PC_E=pc, branch_taken_E=
//    branch_cond_E; otherwise update_en=0 and PC_E/branch_taken_E hold last value. Latency 1.
//    Alias case (not a branch) never updates the BHT.
//  - Counters: branch_count += 1 on resolve & is_branch_E; mispredict_count += 1 on
//    mispredict_E; both saturate at all-ones, never wrap. Registered, visible next cycle.
//  - flush_E with stall_E same cycle: flush wins, E becomes bubble, no resolution.
//  - Reset (async, any time incl. mid-resolve): all valid bits, update_en, PC_E,
//    branch_taken_E, counters -> 0; mispredict_E=0 and redirect_PC_E=0 while rst=1.
// TESTING
//  - Branch @0x100 pred=0, cond=1, target 0x200 -> mispredict_E=1, redirect 0x200; next cyc
//    update_en=1, PC_E=0x100, branch_taken_E=1; mispredict_count=1, branch_count=1.
//  - Branch @0x104 pred=1, target 0x180 match, cond=1 -> no mispredict; update_en=1 once.
//  - Same branch with stall_E held 3 cycles -> single update pulse, counters +1 only on release.
//  - pred=1 on non-branch @0xFFFFFFFC -> redirect 0x00000000, update_en stays 0, mispredict +1.
//  - CNT_W=4, 20 mispredicts -> mispredict_count stops at 0xF; flush_E+stall_E -> no resolve.
//  - Assert rst mid-stream with valid E -> outputs and counters 0 immediately, no update after.

Source files
------------

// File: rtl/branch_resolution_unit.sv
// ============================================================================
// Module   : branch_resolution_unit
// Purpose  : Carries fetch predictions through D/E, resolves them in E, trains
//            the BHT and keeps saturating branch/mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolution_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_F,
    input  logic [31:0]      PC_F,
    input  logic             predict_taken_F,
    input  logic [31:0]      pred_target_F,
    input  logic             stall_D,
    input  logic             stall_E,
    input  logic             flush_D,
    input  logic             flush_E,
    input  logic             is_branch_E,
    input  logic             branch_cond_E,
    input  logic [31:0]      branch_target_E,
    output logic             mispredict_E,
    output logic [31:0]      redirect_PC_E,
    output logic             update_en,
    output logic [31:0]      PC_E,
    output logic             branch_taken_E,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic        r_d_valid;
    logic        r_d_pred;
    logic [31:0] r_d_pc;
    logic [31:0] r_d_tgt;
    logic        r_e_valid;
    logic        r_e_pred;
    logic [31:0] r_e_pc;
    logic [31:0] r_e_tgt;

    logic        w_resolve;
    logic        w_dir_wrong;
    logic        w_tgt_wrong;
    logic        w_mispredict;
    logic [31:0] w_redirect;

    // Non-branches only ever "mispredict" when the BHT aliased them as taken.
    always_comb begin
        w_resolve    = r_e_valid & ~stall_E & ~rst;
        w_dir_wrong  = is_branch_E ? (r_e_pred != branch_cond_E) : r_e_pred;
        w_tgt_wrong  = is_branch_E & branch_cond_E & r_e_pred & (r_e_tgt != branch_target_E);
        w_mispredict = w_resolve & (w_dir_wrong | w_tgt_wrong);
        w_redirect   = 32'd0;
        if (w_mispredict) begin
            w_redirect = (is_branch_E & branch_cond_E) ? branch_target_E : (r_e_pc + 32'd4);
        end
    end

    assign mispredict_E  = w_mispredict;
    assign redirect_PC_E = w_redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_valid <= 1'b0;
            r_d_pred  <= 1'b0;
            r_d_pc    <= 32'd0;
            r_d_tgt   <= 32'd0;
        end else if (flush_D || w_mispredict) begin
            r_d_valid <= 1'b0;
        end else if (!stall_D) begin
            r_d_valid <= valid_F;
            r_d_pred  <= predict_taken_F;
            r_d_pc    <= PC_F;
            r_d_tgt   <= pred_target_F;
        end
    end

    // The D occupant is wrong-path on a mispredict, so it must not reach E.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_valid <= 1'b0;
            r_e_pred  <= 1'b0;
            r_e_pc    <= 32'd0;
            r_e_tgt   <= 32'd0;
        end else if (flush_E) begin
            r_e_valid <= 1'b0;
        end else if (!stall_E) begin
            r_e_valid <= r_d_valid & ~stall_D & ~w_mispredict;
            r_e_pred  <= r_d_pred;
            r_e_pc    <= r_d_pc;
            r_e_tgt   <= r_d_tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update_en      <= 1'b0;
            PC_E           <= 32'd0;
            branch_taken_E <= 1'b0;
        end else if (w_resolve && is_branch_E) begin
            update_en      <= 1'b1;
            PC_E           <= r_e_pc;
            branch_taken_E <= branch_cond_E;
        end else begin
            update_en      <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (w_resolve && is_branch_E && (branch_count != c_CNT_MAX)) begin
                branch_count <= branch_count + 1'b1;
            end
            if (w_mispredict && (mispredict_count != c_CNT_MAX)) begin
                mispredict_count <= mispredict_count + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
